// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue feeding decode, with redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_rden,
  output logic [13:0]                imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_npc,
  output logic [31:0]                id_instr,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          pending;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          fifo_valid;
  logic          bypass_hit;
  logic          push;
  logic          pop;
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;

  // The outstanding read reserves a slot, so a response always has room.
  assign imem_rden = rst_n & ~redirect & ((int'(count) + int'(pending)) < DEPTH);
  assign imem_addr = fetch_pc[15:2];
  assign q_count   = count;

  always_comb begin
    fifo_valid = (count != '0);
    bypass_hit = 1'b0;
    head_pc    = pc_mem[rd_ptr];
    head_instr = instr_mem[rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_hit = pending & ~redirect & ~fifo_valid;
    if (bypass_hit) begin
      head_pc    = pending_pc;
      head_instr = imem_dout;
    end
`endif
    id_valid = fifo_valid | bypass_hit;
    id_pc    = id_valid ? head_pc : 32'h0;
    id_npc   = id_valid ? head_pc + 32'd4 : 32'h0;
    id_instr = id_valid ? head_instr : 32'h0;
    pop      = fifo_valid & id_ready & ~redirect;
    push     = pending & ~redirect & ~(bypass_hit & id_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= 32'h0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= imem_rden;
      if (imem_rden) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pending_pc;
      instr_mem[wr_ptr] <= imem_dout;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue against a sequential-PC model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int FIRST_LAT = 1;
  localparam int RED_LAT   = 2;
`else
  localparam int FIRST_LAT = 2;
  localparam int RED_LAT   = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rden;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_npc;
  logic [31:0] id_instr;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rden(imem_rden), .imem_addr(imem_addr),
    .imem_dout(imem_dout), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_npc(id_npc),
    .id_instr(id_instr), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Memory model: word k holds 0x1000+k, one-cycle read latency.
  always @(posedge clk) if (imem_rden) imem_dout <= 32'h1000 + {18'b0, imem_addr};

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000 + {18'b0, pc[15:2]};
  endfunction

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    id_ready = rdy;
    redirect = redir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic restart(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0;
    id_ready = rdy;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", id_valid); end
    n_checks++; if (imem_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden got %b want 0", imem_rden); end
    n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", q_count); end
    n_checks++; if ({id_pc, id_npc, id_instr} !== 96'h0) begin n_fail++; $display("FAIL reset_outputs got %h %h %h want 0", id_pc, id_npc, id_instr); end
  endtask

  task automatic test_straight_line;
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    restart(1'b1);
    n_checks++; if (imem_rden !== 1'b1 || imem_addr !== 14'd0) begin n_fail++; $display("FAIL first_req got rden=%b addr=%h want 1 0", imem_rden, imem_addr); end
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (cyc > 0) step(1'b1, 1'b0, 32'h0);
      if (cyc < FIRST_LAT) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL straight_early_valid cyc %0d got %b want 0", cyc, id_valid); end
      end else begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== exp_pc || id_npc !== exp_pc + 32'd4 || id_instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL straight_seq cyc %0d got v=%b pc=%h npc=%h ins=%h want v=1 pc=%h ins=%h", cyc, id_valid, id_pc, id_npc, id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_pc;
    int delivered;
    restart(1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0);
    n_checks++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL bp_count got %0d want 4", q_count); end
    n_checks++; if (imem_rden !== 1'b0) begin n_fail++; $display("FAIL bp_rden got %b want 0", imem_rden); end
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head got v=%b pc=%h want 1 0", id_valid, id_pc); end
    exp_pc = 32'h0;
    delivered = 0;
    for (int cyc = 0; cyc < 40 && delivered < 8; cyc++) begin
      step(1'b1, 1'b0, 32'h0);
      if (id_valid) begin
        n_checks++;
        if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL bp_order got pc=%h ins=%h want pc=%h ins=%h", id_pc, id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        delivered++;
      end
    end
    n_checks++; if (delivered != 8) begin n_fail++; $display("FAIL bp_delivered got %0d want 8", delivered); end
  endtask

  task automatic test_flush;
    logic [31:0] exp_pc;
    bit reached;
    reached = 0;
    restart(1'b0);
    for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
      if (q_count == 3'd3) reached = 1;
      else step(1'b0, 1'b0, 32'h0);
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL flush_fill got count=%0d want 3", q_count); end
    step(1'b1, 1'b1, 32'h0000_0103);
    n_checks++; if (imem_rden !== 1'b0 || id_valid !== 1'b1) begin n_fail++; $display("FAIL flush_rcycle got rden=%b v=%b want 0 1", imem_rden, id_valid); end
    exp_pc = 32'h100;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (k == 1) begin
        n_checks++;
        if (q_count !== 3'd0 || imem_rden !== 1'b1 || imem_addr !== 14'h40) begin
          n_fail++; $display("FAIL flush_r1 got count=%0d rden=%b addr=%h want 0 1 40", q_count, imem_rden, imem_addr);
        end
      end
      if (k < RED_LAT) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gap r+%0d got v=%b want 0", k, id_valid); end
      end else if (k == RED_LAT) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_npc !== 32'h104) begin
          n_fail++; $display("FAIL flush_target got v=%b pc=%h npc=%h want 1 100 104", id_valid, id_pc, id_npc);
        end
      end
      if (id_valid) begin
        n_checks++;
        if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL flush_seq got pc=%h ins=%h want pc=%h ins=%h", id_pc, id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_random_redirect;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        rdy;
    logic        redir;
    logic        prev_hold;
    logic [31:0] prev_pc;
    restart(1'b1);
    exp_pc = 32'h0;
    prev_hold = 1'b0;
    prev_pc = 32'h0;
    repeat (4) step(1'b1, 1'b0, 32'h0);
    exp_pc = 32'h8;
    // Redirect with a live handshake: the head must not be consumed.
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL hs_valid_before got %b want 1", id_valid); end
    step(1'b1, 1'b1, 32'h0000_2002);
    exp_pc = 32'h2000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      redir = ($urandom_range(0, 9) == 0);
      rdy   = redir ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      tgt   = $urandom;
      step(rdy, redir, tgt);
      if (prev_hold) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== prev_pc) begin
          n_fail++; $display("FAIL rnd_hold got v=%b pc=%h want 1 %h", id_valid, id_pc, prev_pc);
        end
      end
      n_checks++; if (q_count > 3'd4) begin n_fail++; $display("FAIL rnd_count got %0d want <=4", q_count); end
      if (redir) begin
        n_checks++; if (imem_rden !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_rden got %b want 0", imem_rden); end
        exp_pc = {tgt[31:2], 2'b00};
      end else if (id_valid && rdy) begin
        n_checks++;
        if (id_pc !== exp_pc || id_npc !== exp_pc + 32'd4 || id_instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_seq got pc=%h npc=%h ins=%h want pc=%h ins=%h", id_pc, id_npc, id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
      prev_hold = id_valid & ~rdy & ~redir;
      prev_pc   = id_pc;
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] exp_pc;
    bit reached;
    reached = 0;
    restart(1'b0);
    for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
      if (q_count == 3'd2) reached = 1;
      else step(1'b0, 1'b0, 32'h0);
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL ar_fill got count=%0d want 2", q_count); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_rden !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate got v=%b count=%0d rden=%b want 0 0 0", id_valid, q_count, imem_rden);
    end
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = 1'b1;
    #1;
    n_checks++; if (imem_rden !== 1'b1 || imem_addr !== 14'd0) begin n_fail++; $display("FAIL ar_resume got rden=%b addr=%h want 1 0", imem_rden, imem_addr); end
    exp_pc = 32'h0;
    for (int cyc = 1; cyc < 12; cyc++) begin
      step(1'b1, 1'b0, 32'h0);
      if (id_valid) begin
        n_checks++;
        if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL ar_seq got pc=%h ins=%h want pc=%h ins=%h", id_pc, id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (exp_pc == 32'h0) begin n_fail++; $display("FAIL ar_nothing_delivered got 0 items want >0"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_flush();
    test_random_redirect();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

- Instruction prefetch stage between the instruction port of the OTTER memory and the decode stage of the 5-stage pipeline.
- Issues sequential word fetches and buffers returned instructions with their PC/NPC in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Flushes itself and restarts at a new PC when execute signals a redirect (branch, jump, trap, mret).

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IMEM_RDEN  out  1  instruction read request this cycle.
- IMEM_ADDR  out  14  word address, fetch_pc[15:2].
- IMEM_DOUT  in  32  read data, valid the cycle after IMEM_RDEN.
- REDIRECT  in  1  flush and restart fetch.
- REDIRECT_PC  in  32  restart address; bits [1:0] ignored (forced 0).
- ID_VALID  out  1  head entry valid.
- ID_READY  in  1  decode accepts head.
- ID_PC  out  32  PC of head entry.
- ID_NPC  out  32  ID_PC + 4.
- ID_INSTR  out  32  instruction of head entry.
- Q_COUNT  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State:
  - fetch_pc register.
  - pending flag + pending_pc: one outstanding read, fixed 1-cycle latency.
  - FIFO of {pc, instr} with read/write pointers (wrap modulo DEPTH) and count.
- Issue condition: IMEM_RDEN = RST_N & !REDIRECT & (count + pending < DEPTH). Combinational; pop in the same cycle is not credited.
- On issue: pending <= 1, pending_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap).
- Pending response: written to FIFO tail at the edge ending the IMEM_DOUT cycle.
- Pop: ID_VALID & ID_READY & !REDIRECT advances the head.
- Push and pop in the same cycle: count unchanged.
- The reservation rule makes overflow impossible.
- Redirect cycle:
  - Count, pointers, and pending are cleared.
  - Any response due next cycle is dropped.
  - fetch_pc <= {REDIRECT_PC[31:2], 2'b00}.
  - No request is issued and any pop is discarded.
- Repeated REDIRECT in consecutive cycles: the last one wins.
- ID_VALID = (count != 0). ID_PC/ID_NPC/ID_INSTR come from the head entry and hold stable while ID_VALID & !ID_READY.

## Timing
- Reset (RST_N low, asynchronous): ID_VALID=0, IMEM_RDEN=0, Q_COUNT=0, ID_PC/ID_NPC/ID_INSTR=0, pending=0, fetch_pc=RESET_PC.
- First request: in cycle 0 after RST_N deasserts, with IMEM_ADDR=RESET_PC[15:2].
- Fetch-to-decode latency: request in cycle n, data in cycle n+1, ID_VALID in cycle n+2.
- Redirect latency:
  - REDIRECT in cycle r.
  - Request to the target in cycle r+1.
  - ID_VALID=1 with ID_PC=target in cycle r+3.
  - ID_VALID=0 in cycles r+1 and r+2.
- Throughput: one instruction per cycle with ID_READY held high when DEPTH≥3. DEPTH=2 sustains ≥1 per 2 cycles.
- Reset mid-operation: all state is discarded immediately. An in-flight response is never written.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the FIFO is empty and a valid (non-dropped) response arrives, it drives ID_VALID/ID_PC/ID_NPC/ID_INSTR combinationally in that cycle.
  - If ID_READY=1 it is consumed and not written to the FIFO; otherwise it is written.
  - Redirect latency drops to ID_VALID in cycle r+2; fetch latency drops to n+1.
- Not defined: outputs come only from FIFO storage (registered path), with the latencies given above.

## Test plan
- Straight line: RESET_PC=0, memory word k = 0x1000+k, ID_READY=1 → ID_VALID first in cycle 2 after reset release. Then ID_PC=0,4,8,… with ID_INSTR=0x1000,0x1001,… and ID_NPC=ID_PC+4, one per cycle, with no gaps.
- Backpressure: ID_READY=0 from cycle 2 → Q_COUNT reaches 4 and IMEM_RDEN stays 0; head stays ID_PC=0. Release ID_READY → PCs 0..0x1C delivered in order, no loss or duplicate.
- Flush with in-flight read: Q_COUNT=3, pending=1, REDIRECT_PC=0x103 in cycle r → Q_COUNT=0 at r+1; stale data never appears. ID_VALID=0 at r+1 and r+2; ID_PC=0x100, ID_NPC=0x104 at r+3.
- Redirect with simultaneous handshake: ID_VALID=ID_READY=1 in the REDIRECT cycle → the pop is discarded and the next delivered PC is the redirect target.
- Async reset: RST_N driven low mid-cycle while Q_COUNT=2 → ID_VALID and Q_COUNT go to 0 before the next edge. Fetch resumes at RESET_PC.
- Macro FETCH_QUEUE_BYPASS_EN defined: the redirect test gives ID_VALID with ID_PC=0x100 at r+2, and straight-line first ID_VALID in cycle 1.
